// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - word-addressed data memory with wait-state request/ack handshake
// Optional macro DMEM_RANGE_CHK_EN adds Mem_err and suppresses out-of-range accesses.
module data_mem_unit #(
  parameter int N     = 16,
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Mem_req,
  input  logic         Mem_we,
  input  logic [N-1:0] Addr,
  input  logic [N-1:0] Data_write,
  output logic [N-1:0] Data_out,
  output logic         Mem_busy,
`ifdef DMEM_RANGE_CHK_EN
  output logic         Mem_err,
`endif
  output logic         Mem_ack
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_ST, DONE_ST} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic           we_q;
  logic [N-1:0]   addr_q;
  logic [N-1:0]   data_q;
  logic [N-1:0]   mem [DEPTH];

  logic           go_done;
  logic           c_we;
  logic [N-1:0]   c_addr;
  logic [N-1:0]   c_data;
  logic [AW-1:0]  c_idx;
  logic           in_range;
  logic           commit;

  // With zero wait states the commit happens on the request edge itself,
  // so the access fields come straight from the inputs instead of the latches.
  always_comb begin
    go_done = 1'b0;
    c_we    = we_q;
    c_addr  = addr_q;
    c_data  = data_q;
    if (state == IDLE) begin
      go_done = Mem_req && (WAIT == 0);
      c_we    = Mem_we;
      c_addr  = Addr;
      c_data  = Data_write;
    end else if (state == WAIT_ST) begin
      go_done = (cnt == 4'd1);
    end
  end

  assign c_idx = c_addr[AW-1:0];

`ifdef DMEM_RANGE_CHK_EN
  localparam logic [N:0] DEPTH_W = (N+1)'(DEPTH);
  assign in_range = ({1'b0, c_addr} < DEPTH_W);
`else
  logic unused_hi;
  assign in_range  = 1'b1;
  assign unused_hi = ^c_addr[N-1:AW];
`endif

  assign commit = go_done && in_range;

  always_ff @(posedge clk) begin
    if (!rst && commit && c_we)
      mem[c_idx] <= c_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      Data_out <= '0;
      Mem_busy <= 1'b0;
      Mem_ack  <= 1'b0;
`ifdef DMEM_RANGE_CHK_EN
      Mem_err  <= 1'b0;
`endif
    end else begin
      Mem_ack <= 1'b0;
`ifdef DMEM_RANGE_CHK_EN
      Mem_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Mem_req) begin
            we_q     <= Mem_we;
            addr_q   <= Addr;
            data_q   <= Data_write;
            cnt      <= 4'(WAIT);
            Mem_busy <= 1'b1;
            state    <= (WAIT == 0) ? DONE_ST : WAIT_ST;
          end
        end
        WAIT_ST: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= DONE_ST;
        end
        DONE_ST: begin
          state    <= IDLE;
          Mem_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (go_done) begin
        Mem_ack <= 1'b1;
`ifdef DMEM_RANGE_CHK_EN
        Mem_err <= !in_range;
`endif
      end
      if (commit && !c_we)
        Data_out <= mem[c_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb/tb_data_mem_unit.sv - directed self-checking bench for data_mem_unit
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Mem_req = 1'b0;
  logic        Mem_we = 1'b0;
  logic [15:0] Addr = '0;
  logic [15:0] Data_write = '0;
  logic [15:0] Data_out;
  logic        Mem_busy;
  logic        Mem_ack;
`ifdef DMEM_RANGE_CHK_EN
  logic        Mem_err;
`endif

  int total = 0;
  int bad   = 0;

  data_mem_unit #(.N(16), .DEPTH(256), .WAIT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .Mem_req    (Mem_req),
    .Mem_we     (Mem_we),
    .Addr       (Addr),
    .Data_write (Data_write),
    .Data_out   (Data_out),
    .Mem_busy   (Mem_busy),
`ifdef DMEM_RANGE_CHK_EN
    .Mem_err    (Mem_err),
`endif
    .Mem_ack    (Mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one access; lat is the edge count from request to ack, 0 on timeout.
  task automatic do_access(input logic we, input logic [15:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] dout,
                           output logic busy1, output logic err);
    Mem_req = 1'b1; Mem_we = we; Addr = a; Data_write = d;
    lat = 0; dout = 'x; busy1 = 1'b0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        Mem_req = 1'b0;
        busy1 = Mem_busy;
      end
      if (Mem_ack) begin
        lat  = i;
        dout = Data_out;
`ifdef DMEM_RANGE_CHK_EN
        err  = Mem_err;
`endif
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (Data_out !== 16'h0000) begin bad++; $display("FAIL reset_data_out got=%h want=0000", Data_out); end
    total++; if (Mem_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Mem_busy); end
    total++; if (Mem_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", Mem_ack); end
  endtask

  task automatic test_store_load();
    int lat; logic [15:0] dout; logic b1, err;
    do_access(1'b1, 16'd5, 16'h00A5, lat, dout, b1, err);
    total++; if (lat !== 3) begin bad++; $display("FAIL store_latency got=%0d want=3", lat); end
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL store_busy got=%b want=1", b1); end
    total++; if (Mem_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", Mem_busy); end
    do_access(1'b0, 16'd5, 16'h0000, lat, dout, b1, err);
    total++; if (lat !== 3) begin bad++; $display("FAIL load_latency got=%0d want=3", lat); end
    total++; if (dout !== 16'h00A5) begin bad++; $display("FAIL load_data got=%h want=00a5", dout); end
  endtask

  task automatic test_ignore_req();
    int acks = 0;
    Mem_req = 1'b1; Mem_we = 1'b0; Addr = 16'd5;
    tick();
    Mem_req = 1'b0;
    tick();
    Mem_req = 1'b1; Addr = 16'd9;
    tick();
    if (Mem_ack) acks++;
    Mem_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (Mem_ack) acks++;
    end
    total++; if (acks !== 1) begin bad++; $display("FAIL ignore_req_acks got=%0d want=1", acks); end
    total++; if (Data_out !== 16'h00A5) begin bad++; $display("FAIL ignore_req_data got=%h want=00a5", Data_out); end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int pos[3] = '{0, 0, 0};
    Mem_req = 1'b1; Mem_we = 1'b0; Addr = 16'd5;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (Mem_ack) begin
        if (acks < 3) pos[acks] = i;
        acks++;
      end
    end
    Mem_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (Mem_ack) acks++;
    end
    total++; if (acks !== 3) begin bad++; $display("FAIL b2b_ack_count got=%0d want=3", acks); end
    total++; if (pos[0] !== 3) begin bad++; $display("FAIL b2b_first_ack got=%0d want=3", pos[0]); end
    total++; if (pos[1] - pos[0] !== 4) begin bad++; $display("FAIL b2b_gap1 got=%0d want=4", pos[1] - pos[0]); end
    total++; if (pos[2] - pos[1] !== 4) begin bad++; $display("FAIL b2b_gap2 got=%0d want=4", pos[2] - pos[1]); end
  endtask

  task automatic test_reset_abort();
    int lat; int acks = 0; logic [15:0] dout; logic b1, err;
    do_access(1'b1, 16'd3, 16'h5555, lat, dout, b1, err);
    Mem_req = 1'b1; Mem_we = 1'b1; Addr = 16'd3; Data_write = 16'h1234;
    tick();
    Mem_req = 1'b0;
    total++; if (Mem_busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b want=1", Mem_busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (Mem_busy !== 1'b0) begin bad++; $display("FAIL abort_busy_after got=%b want=0", Mem_busy); end
    for (int i = 0; i < 5; i++) begin
      if (Mem_ack) acks++;
      tick();
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL abort_ack got=%0d want=0", acks); end
    do_access(1'b0, 16'd3, 16'h0000, lat, dout, b1, err);
    total++; if (dout !== 16'h5555) begin bad++; $display("FAIL abort_no_write got=%h want=5555", dout); end
    // Reset asserted together with a request drops the request.
    rst = 1'b1; Mem_req = 1'b1; Mem_we = 1'b1; Addr = 16'd3; Data_write = 16'hDEAD;
    tick();
    rst = 1'b0; Mem_req = 1'b0;
    total++; if (Mem_busy !== 1'b0) begin bad++; $display("FAIL rst_req_busy got=%b want=0", Mem_busy); end
    do_access(1'b0, 16'd3, 16'h0000, lat, dout, b1, err);
    total++; if (dout !== 16'h5555) begin bad++; $display("FAIL rst_req_dropped got=%h want=5555", dout); end
  endtask

  task automatic test_wrap();
    int lat; logic [15:0] dout; logic b1, err;
    do_access(1'b1, 16'h0107, 16'h0BEE, lat, dout, b1, err);
    do_access(1'b0, 16'h0007, 16'h0000, lat, dout, b1, err);
    total++; if (dout !== 16'h0BEE) begin bad++; $display("FAIL wrap_load got=%h want=0bee", dout); end
    do_access(1'b1, 16'h00FF, 16'hC0DE, lat, dout, b1, err);
    do_access(1'b0, 16'h00FF, 16'h0000, lat, dout, b1, err);
    total++; if (dout !== 16'hC0DE) begin bad++; $display("FAIL top_word got=%h want=c0de", dout); end
`ifndef DMEM_RANGE_CHK_EN
    do_access(1'b0, 16'hFFFF, 16'h0000, lat, dout, b1, err);
    total++; if (dout !== 16'hC0DE) begin bad++; $display("FAIL wrap_ffff got=%h want=c0de", dout); end
`endif
  endtask

`ifdef DMEM_RANGE_CHK_EN
  task automatic test_range();
    int lat; logic [15:0] dout; logic b1, err;
    do_access(1'b1, 16'd44, 16'h4444, lat, dout, b1, err);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL inrange_err got=%b want=0", err); end
    do_access(1'b1, 16'd300, 16'h9999, lat, dout, b1, err);
    total++; if (lat !== 3) begin bad++; $display("FAIL oor_latency got=%0d want=3", lat); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_store_err got=%b want=1", err); end
    do_access(1'b0, 16'd44, 16'h0000, lat, dout, b1, err);
    total++; if (dout !== 16'h4444) begin bad++; $display("FAIL oor_ram_unchanged got=%h want=4444", dout); end
    do_access(1'b0, 16'd300, 16'h0000, lat, dout, b1, err);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_load_err got=%b want=1", err); end
    total++; if (dout !== 16'h4444) begin bad++; $display("FAIL oor_load_hold got=%h want=4444", dout); end
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_ignore_req();
    test_back_to_back();
    test_reset_abort();
    test_wrap();
`ifdef DMEM_RANGE_CHK_EN
    test_range();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
